keccak_absorb_ctrl: RTL and testbench
=====================================

KECCAK_ABSORB_CTRL -- requirements
Module: keccak_absorb_ctrl

Interface
REQ-001 The block SHALL have parameter l, default 6, meaning Keccak lane-size exponent (b = 25*2**l).
REQ-002 The block SHALL have parameter d, default 112, meaning digest width in bits (c = 2*d, r = b - c, R = r/8 bytes per block).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, 8 bits, meaning the message byte.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning in_data is valid.
REQ-007 The block SHALL have port in_last, input, 1 bit, meaning this is the final message byte; qualified by in_valid.
REQ-008 The block SHALL have port in_flush, input, 1 bit, meaning end of message with no further byte (covers empty messages).
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning a byte or flush is accepted this cycle.
REQ-010 The block SHALL have port block, output, r bits, meaning the padded rate block; byte k at bits [8k+7:8k].
REQ-011 The block SHALL have port block_valid, output, 1 bit, meaning block is presented to the sponge.
REQ-012 The block SHALL have port block_ready, input, 1 bit, meaning the sponge absorbs block this cycle (drives its enable).
REQ-013 The block SHALL have port block_first, output, 1 bit, meaning block is the first of a message; the sponge clears its state.
REQ-014 The block SHALL have port block_last, output, 1 bit, meaning block carries the final padding; the digest is valid after absorption.
REQ-015 The block SHALL have port msg_done, output, 1 bit, meaning a one-cycle pulse, the cycle after the last-block handshake.

Function
REQ-016 The block SHALL require r to be a multiple of 8; other values are unsupported.
REQ-017 The block SHALL implement a two-state FSM: FILL, with in_ready=1 and block_valid=0, and EMIT, with in_ready=0 and block_valid=1.
REQ-018 The block SHALL keep a byte index idx in 0..R-1, a final flag, a pad_pending flag and a first_pending flag.
REQ-019 In FILL, an accepted byte (in_valid=1) SHALL be written at idx, with idx incremented.
REQ-020 In FILL, an accepted non-last byte with idx=R-1 SHALL cause a transition to EMIT with final=0.
REQ-021 In FILL, an accepted last byte with idx<R-1 SHALL write 0x06 at idx+1 and OR 0x80 into byte R-1, giving 0x86 when idx+1=R-1, then transition to EMIT with final=1.
REQ-022 In FILL, an accepted last byte with idx=R-1 SHALL transition to EMIT with final=0 and pad_pending=1.
REQ-023 In FILL, in_flush=1 with in_valid=0 SHALL write 0x06 at idx and OR 0x80 into byte R-1 (0x86 when idx=R-1), then transition to EMIT with final=1.
REQ-024 When in_flush=1 and in_valid=1 coincide, the block SHALL treat the cycle as an in_last byte.
REQ-025 In EMIT, block, block_first and block_last SHALL stay stable until the block_valid&&block_ready handshake.
REQ-026 block_last SHALL equal final, and block_first SHALL equal first_pending; both SHALL be 0 when block_valid=0.
REQ-027 On handshake with pad_pending=1, the buffer SHALL become a pad-only block (byte 0 = 0x06, byte R-1 = 0x80, rest 0), with final=1, pad_pending=0, first_pending=0, and the FSM staying in EMIT.
REQ-028 On handshake with final=1, the block SHALL clear the buffer, set idx=0, set first_pending=1, pulse msg_done the next cycle and return to FILL.
REQ-029 On handshake otherwise, the block SHALL clear the buffer, set idx=0, set first_pending=0 and return to FILL.
REQ-030 Buffer bytes not written SHALL be 0.
REQ-031 Throughput SHALL be one byte per cycle in FILL plus at least one EMIT cycle per block.
REQ-032 block_ready SHALL be ignored in FILL, and in_valid/in_flush SHALL be ignored in EMIT.

Reset
REQ-033 While reset=1, and immediately on its assertion regardless of clk: FSM=FILL, idx=0, final=0, pad_pending=0, first_pending=1, buffer all 0.
REQ-034 Reset output values SHALL be: in_ready=1, block_valid=0, block=0, block_first=0, block_last=0, msg_done=0.
REQ-035 Reset mid-message SHALL discard partial data, and the next emitted block SHALL have block_first=1.

Verification (l=6, d=112: r=1376, R=172)
REQ-036 The bench SHALL cover: in_flush at idx 0 -> one block with byte0=0x06, byte171=0x80, rest 0, first=1, last=1, and a msg_done pulse after the handshake.
REQ-037 The bench SHALL cover: bytes 0x61,0x62,0x63 with in_last on 0x63 -> bytes 0..3 = 61 62 63 06, byte171=0x80, first=1, last=1.
REQ-038 The bench SHALL cover: 171 bytes, last on the 171st -> one block with byte171=0x86, last=1.
REQ-039 The bench SHALL cover: 172 bytes, last on the 172nd -> block A (data, first=1, last=0), then block B (byte0=0x06, byte171=0x80, first=0, last=1); msg_done only after B.
REQ-040 The bench SHALL cover: block_ready held low for 5 cycles in EMIT -> block and flags stable, in_ready=0, inputs ignored, and exactly one handshake.
REQ-041 The bench SHALL cover: reset asserted after 50 bytes -> in_ready=1 and block_valid=0 at once; a new 3-byte message then yields first=1 with no residue of the old data.

Source files
------------

// File: rtl/keccak_absorb_ctrl.sv
// keccak_absorb_ctrl
//   Collects a byte stream into Keccak rate blocks, applies the SHA-3
//   pad10*1 padding (0x06 ... 0x80) and hands each block to the sponge.
//
// Parameters
//   l : lane-size exponent, state width b = 25*2**l
//   d : digest width in bits, capacity c = 2*d, rate r = b - c (multiple of 8)
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high reset
//   in_data     : message byte
//   in_valid    : in_data valid
//   in_last     : final message byte (qualified by in_valid)
//   in_flush    : end of message without a byte (empty-message / byte-less end)
//   in_ready    : byte or flush accepted this cycle
//   block       : padded rate block, byte k at bits [8k+7:8k]
//   block_valid : block presented to the sponge
//   block_ready : sponge absorbs block this cycle
//   block_first : block is the first of a message
//   block_last  : block carries the final padding
//   msg_done    : one-cycle pulse after the last-block handshake
module keccak_absorb_ctrl #(
    parameter int l = 6,
    parameter int d = 112
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic                          in_flush,
    output logic                          in_ready,
    output logic [25*(2**l)-2*d-1:0]      block,
    output logic                          block_valid,
    input  logic                          block_ready,
    output logic                          block_first,
    output logic                          block_last,
    output logic                          msg_done
);

    localparam int RBITS = 25 * (2 ** l) - 2 * d;
    localparam int NB    = RBITS / 8;
    localparam int IW    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LASTIDX = IW'(NB - 1);

    typedef enum logic {
        FILL,
        EMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [NB-1:0][7:0]     buf_q, buf_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   fin_q, fin_d;
    logic                   pad_q, pad_d;
    logic                   first_q, first_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            buf_q   <= '0;
            idx_q   <= '0;
            fin_q   <= 1'b0;
            pad_q   <= 1'b0;
            first_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            fin_q   <= fin_d;
            pad_q   <= pad_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        fin_d   = fin_q;
        pad_d   = pad_q;
        first_d = first_q;
        done_d  = 1'b0;

        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    buf_d[idx_q] = in_data;
                    // in_flush alongside a byte ends the message like in_last
                    if (in_last || in_flush) begin
                        state_d = EMIT;
                        if (idx_q == LASTIDX) begin
                            // no room for padding: a pad-only block follows
                            fin_d = 1'b0;
                            pad_d = 1'b1;
                        end else begin
                            buf_d[idx_q + IW'(1)] = 8'h06;
                            buf_d[NB-1][7]        = 1'b1;
                            fin_d                 = 1'b1;
                        end
                    end else if (idx_q == LASTIDX) begin
                        state_d = EMIT;
                        fin_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (in_flush) begin
                    // 0x06 and 0x80 merge into 0x86 when idx is the top byte
                    buf_d[idx_q]   = 8'h06;
                    buf_d[NB-1][7] = 1'b1;
                    fin_d          = 1'b1;
                    state_d        = EMIT;
                end
            end

            EMIT: begin
                if (block_ready) begin
                    buf_d = '0;
                    idx_d = '0;
                    if (pad_q) begin
                        buf_d[0]       = 8'h06;
                        buf_d[NB-1][7] = 1'b1;
                        fin_d          = 1'b1;
                        pad_d          = 1'b0;
                        first_d        = 1'b0;
                    end else begin
                        state_d = FILL;
                        first_d = fin_q;
                        done_d  = fin_q;
                        fin_d   = 1'b0;
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    assign in_ready    = (state_q == FILL);
    assign block_valid = (state_q == EMIT);
    assign block_first = block_valid && first_q;
    assign block_last  = block_valid && fin_q;
    assign block       = buf_q;
    assign msg_done    = done_q;

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Testbench for keccak_absorb_ctrl (l=6, d=112: 172-byte rate blocks).
// Stimulus pushes the expected padded blocks into a queue; a monitor pops
// and compares on every block handshake and tracks msg_done.
module tb_keccak_absorb_ctrl;

    localparam int NB = 172;

    typedef logic [NB-1:0][7:0] blk_t;
    typedef struct {
        blk_t data;
        bit   first;
        bit   last;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            in_flush = 1'b0;
    logic            in_ready;
    logic [NB*8-1:0] block;
    logic            block_valid;
    logic            block_ready = 1'b0;
    logic            block_first;
    logic            block_last;
    logic            msg_done;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];
    byte unsigned msg[$];
    bit force_low = 1'b0;

    keccak_absorb_ctrl #(.l(6), .d(112)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_flush    (in_flush),
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_first (block_first),
        .block_last  (block_last),
        .msg_done    (msg_done)
    );

    always #5 clk = ~clk;

    initial begin : br_drv
        forever begin
            @(posedge clk);
            #1;
            block_ready = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %b exp %b", nm, got, exp);
        end
    endtask

    // Reference: message ++ 0x06 ++ zeros up to a block multiple, top byte |= 0x80
    function automatic void expect_msg();
        byte unsigned p[$];
        int nblk;
        p = msg;
        p.push_back(8'h06);
        while (p.size() % NB != 0) p.push_back(8'h00);
        p[p.size()-1] = p[p.size()-1] | 8'h80;
        nblk = p.size() / NB;
        for (int b = 0; b < nblk; b++) begin
            exp_t e;
            for (int k = 0; k < NB; k++) e.data[k] = p[b*NB + k];
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            q.push_back(e);
        end
    endfunction

    task automatic drive(input logic [7:0] dat, input logic v, input logic lst, input logic fl);
        bit acc = 1'b0;
        in_data  = dat;
        in_valid = v;
        in_last  = lst;
        in_flush = fl;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout got in_ready=0 exp 1");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_flush = 1'b0;
    endtask

    // mode 0: in_last, 1: flush cycle, 2: in_last+in_flush, 3: in_flush with byte
    task automatic send(input int mode, input bit gaps);
        int n;
        expect_msg();
        n = msg.size();
        for (int i = 0; i < n; i++) begin
            bit lb;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            lb = (i == n - 1) && (mode != 1);
            drive(msg[i], 1'b1, lb && (mode != 3), lb && (mode >= 2));
        end
        if (mode == 1 || n == 0) drive(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic fill_rand(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    task automatic drain();
        for (int t = 0; t < 5000 && q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // Monitor: handshake scoreboard, stall stability, msg_done timing
    initial begin : monitor
        bit exp_done = 1'b0;
        bit have_prev = 1'b0;
        blk_t prev_blk;
        logic prev_first, prev_last;
        forever begin
            bit nd;
            @(negedge clk);
            if (reset) begin
                exp_done  = 1'b0;
                have_prev = 1'b0;
                continue;
            end
            n_cmp++;
            if (msg_done !== exp_done) begin
                n_bad++;
                $display("FAIL msg_done got %b exp %b", msg_done, exp_done);
            end
            nd = 1'b0;
            if (block_valid) begin
                blk_t got;
                got = block;
                if (have_prev) begin
                    n_cmp++;
                    if (got !== prev_blk || block_first !== prev_first || block_last !== prev_last) begin
                        n_bad++;
                        $display("FAIL stall_stable got first=%b last=%b exp first=%b last=%b (or block changed)",
                                 block_first, block_last, prev_first, prev_last);
                    end
                end
                if (block_ready) begin
                    have_prev = 1'b0;
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_block got handshake exp none");
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        nd = e.last;
                        if (block_first !== e.first || block_last !== e.last) begin
                            n_bad++;
                            $display("FAIL block_flags got first=%b last=%b exp first=%b last=%b",
                                     block_first, block_last, e.first, e.last);
                        end else if (got !== e.data) begin
                            n_bad++;
                            for (int k = 0; k < NB; k++) begin
                                if (got[k] !== e.data[k]) begin
                                    $display("FAIL block_byte %0d got %02h exp %02h", k, got[k], e.data[k]);
                                    break;
                                end
                            end
                        end
                    end
                end else begin
                    have_prev  = 1'b1;
                    prev_blk   = got;
                    prev_first = block_first;
                    prev_last  = block_last;
                end
            end else begin
                have_prev = 1'b0;
            end
            exp_done = nd;
        end
    end

    initial begin : main
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_block_valid", block_valid, 1'b0);
        chk1("rst_block_zero", (block == '0), 1'b1);
        chk1("rst_block_first", block_first, 1'b0);
        chk1("rst_block_last", block_last, 1'b0);
        chk1("rst_msg_done", msg_done, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // empty message via flush
        msg.delete();
        send(1, 1'b0);
        drain();

        // "abc"
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        send(0, 1'b0);
        drain();

        // 171 bytes: 0x86 in the top byte
        fill_rand(171);
        send(0, 1'b1);
        drain();

        // 172 bytes: data block then pad-only block
        fill_rand(172);
        send(0, 1'b1);
        drain();

        // sponge stalls 5 cycles; junk inputs must be ignored
        force_low = 1'b1;
        fill_rand(3);
        send(0, 1'b0);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_flush = 1'b1;
        repeat (5) begin
            in_data = 8'($urandom);
            @(negedge clk);
            chk1("stall_in_ready", in_ready, 1'b0);
            chk1("stall_block_valid", block_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_flush = 1'b0;
        force_low = 1'b0;
        drain();

        // reset mid-message after 50 bytes
        fill_rand(50);
        for (int i = 0; i < 50; i++) drive(msg[i], 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_block_valid", block_valid, 1'b0);
        chk1("midrst_block_zero", (block == '0), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        fill_rand(3);
        send(0, 1'b0);
        drain();

        // random messages, random termination style and gaps
        for (int m = 0; m < 10; m++) begin
            fill_rand($urandom_range(0, 400));
            send(int'($urandom_range(0, 3)), 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
